// File: rtl/multiply_pipeline_pkg.sv
// Shared fixed-point constants for the multiply pipeline and related
// datapaths: rounding modes, saturation modes and the Q-format legality check.
package multiply_pipeline_pkg;

    // Rounding modes
    localparam int RND_TRUNC   = 0;
    localparam int RND_HALF_UP = 1;

    // Saturation modes
    localparam int SAT_WRAP  = 0;
    localparam int SAT_CLAMP = 1;

    // A Q format is legal when it has at least one fractional bit
    // and no more fractional bits than the word width.
    function automatic bit fixed_fmt_ok(input int w, input int q);
        return (q >= 1) && (q <= w);
    endfunction

endpackage

// File: rtl/multiply_pipeline_fixed_round_sat.sv
// Combinational rescale of a 2W-bit signed Q(2Q) product back to W-bit QQ.
// Ports: prod (2W product in) -> res (W-bit result), ovf (range overflow).
module fixed_round_sat
    import multiply_pipeline_pkg::*;
#(
    parameter int W   = 16,
    parameter int Q   = 8,
    parameter int RND = RND_HALF_UP,
    parameter int SAT = SAT_CLAMP
) (
    input  logic [2*W-1:0] prod,
    output logic [W-1:0]   res,
    output logic           ovf
);

    // One extra bit so the rounding bias can never wrap the sum.
    localparam int PW = 2*W + 1;
    localparam logic [PW-1:0] BIAS =
        (RND == RND_HALF_UP) ? (PW'(1) << (Q-1)) : '0;

    logic signed [PW-1:0] ext;
    logic signed [PW-1:0] sum;
    logic signed [PW-1:0] r;
    logic [PW-W:0]        top;

    assign ext = {prod[2*W-1], prod};
    assign sum = ext + $signed(BIAS);
    assign r   = sum >>> Q;

    // r fits in W signed bits iff all bits from W-1 upward agree.
    assign top = r[PW-1:W-1];
    assign ovf = ~((&top) | ~(|top));

    always_comb begin
        res = r[W-1:0];
        if ((SAT == SAT_CLAMP) && ovf) begin
            res = r[PW-1] ? {1'b1, {(W-1){1'b0}}}
                          : {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/multiply_pipeline.sv
// Pipelined signed fixed-point multiplier with stb/rdy handshakes.
// Ports: clk, rst (async high); arg_stb/arg_dat{b,a}/arg_rdy in;
//        res_stb/res_dat/res_ovf/res_rdy out. Latency S, 1 beat/cycle.
module multiply_pipeline
    import multiply_pipeline_pkg::*;
#(
    parameter int W   = 16,
    parameter int Q   = 8,
    parameter int S   = 2,
    parameter int RND = RND_HALF_UP,
    parameter int SAT = SAT_CLAMP
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           arg_stb,
    input  logic [2*W-1:0] arg_dat,
    output logic           arg_rdy,
    output logic           res_stb,
    output logic [W-1:0]   res_dat,
    output logic           res_ovf,
    input  logic           res_rdy
);

    if (!fixed_fmt_ok(W, Q) || (S < 2)) begin : g_bad_cfg
        $error("ERROR: multiply_pipeline needs 1 <= Q <= W and S >= 2");
    end

    // Whole pipe moves together; bubbles are kept, not collapsed.
    logic en;
    assign en      = ~res_stb | res_rdy;
    assign arg_rdy = en;

    // Stage 1: full-width signed product.
    logic [2*W-1:0] a_ext;
    logic [2*W-1:0] b_ext;
    logic [2*W-1:0] prod;
    logic           v1;
    logic [2*W-1:0] p1;

    assign a_ext = {{W{arg_dat[W-1]}}, arg_dat[W-1:0]};
    assign b_ext = {{W{arg_dat[2*W-1]}}, arg_dat[2*W-1:W]};
    assign prod  = a_ext * b_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            p1 <= '0;
        end else if (en) begin
            v1 <= arg_stb;
            if (arg_stb) begin
                p1 <= prod;
            end
        end
    end

    // Stage 2 rescale, then plain delay stages 3..S.
    logic [W-1:0] rs_res;
    logic         rs_ovf;

    fixed_round_sat #(
        .W   (W),
        .Q   (Q),
        .RND (RND),
        .SAT (SAT)
    ) u_round (
        .prod (p1),
        .res  (rs_res),
        .ovf  (rs_ovf)
    );

    logic         v [2:S];
    logic [W-1:0] d [2:S];
    logic         o [2:S];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 2; k <= S; k++) begin
                v[k] <= 1'b0;
                d[k] <= '0;
                o[k] <= 1'b0;
            end
        end else if (en) begin
            v[2] <= v1;
            d[2] <= rs_res;
            o[2] <= rs_ovf;
            for (int k = 3; k <= S; k++) begin
                v[k] <= v[k-1];
                d[k] <= d[k-1];
                o[k] <= o[k-1];
            end
        end
    end

    assign res_stb = v[S];
    assign res_dat = d[S];
    assign res_ovf = o[S];

endmodule
